// File: rtl/fp21_pack.sv
// fp21_pack: packs an unpacked float (sign, signed unbiased exponent,
// normalized fraction with hidden bit) into a 21-bit word
// {sign, 7-bit biased exponent, 13-bit mantissa}. Operands that fall below
// the normal range become denormals and are rounded to nearest even.
//
// The block is a three-stage pipeline:
//   stage 1: bias the exponent and classify (ZERO / NORM / OVF / SUB)
//   stage 2: denormalizing shift, guard and sticky extraction
//   stage 3: rounding, result assembly, output register
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds its payload stable while valid is high and
// ready is low. The whole pipeline moves together on advance
// (= !out_valid || out_ready). in_ready is advance itself, so a stalled
// output freezes every stage and the output word and flags hold.
module fp21_pack #(
  parameter int EXP_W  = 9,
  parameter int FRAC_W = 14,
  parameter int BIAS   = 63
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              sign_in,
  input  logic [EXP_W-1:0]  exp_in,
  input  logic [FRAC_W-1:0] frac_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [20:0]       word_out,
  output logic              ovf_out,
  output logic              unf_out,
  output logic              inexact_out
);

  localparam int BW = EXP_W + 1;   // biased exponent width (signed)
  localparam int SW = EXP_W + 2;   // denormal shift width (signed)
  localparam int MW = FRAC_W - 1;  // stored mantissa width

  localparam logic [1:0] CLS_ZERO = 2'd0;
  localparam logic [1:0] CLS_NORM = 2'd1;
  localparam logic [1:0] CLS_OVF  = 2'd2;
  localparam logic [1:0] CLS_SUB  = 2'd3;

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // ---------------- stage 1: bias and classify ----------------
  logic signed [BW-1:0] biased_c;
  logic [1:0]           cls_c;

  logic                 v1;
  logic                 sign1;
  logic [FRAC_W-1:0]    frac1;
  logic signed [BW-1:0] biased1;
  logic [1:0]           cls1;

  // Sign-extend the exponent one bit so adding the bias cannot wrap.
  always_comb begin
    biased_c = $signed({exp_in[EXP_W-1], exp_in}) + $signed(BW'(BIAS));
    if (frac_in == '0)
      cls_c = CLS_ZERO;
    else if (biased_c >= $signed(BW'(127)))
      cls_c = CLS_OVF;
    else if (biased_c <= $signed(BW'(0)))
      cls_c = CLS_SUB;
    else
      cls_c = CLS_NORM;
  end

  // Stage 1 register: captures the operand when it is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1      <= 1'b0;
      sign1   <= 1'b0;
      frac1   <= '0;
      biased1 <= '0;
      cls1    <= CLS_ZERO;
    end else if (advance) begin
      v1      <= in_valid;
      sign1   <= sign_in;
      frac1   <= frac_in;
      biased1 <= biased_c;
      cls1    <= cls_c;
    end
  end

  // ---------------- stage 2: denormalize ----------------
  logic signed [SW-1:0] shift_c;
  logic [3:0]           sh_c;
  logic [MW-1:0]        mant_c;
  logic                 guard_c;
  logic                 sticky_c;

  logic                 v2;
  logic                 sign2;
  logic [1:0]           cls2;
  logic [6:0]           exp2;
  logic [MW-1:0]        mant2;
  logic                 g2;
  logic                 st2;

  // Shift right by 1 - biased; a shift of 15 or more leaves only sticky.
  always_comb begin
    shift_c  = $signed(SW'(1)) - $signed({biased1[BW-1], biased1});
    sh_c     = shift_c[3:0];
    mant_c   = frac1[MW-1:0];
    guard_c  = 1'b0;
    sticky_c = 1'b0;
    if (cls1 == CLS_SUB) begin
      if (shift_c >= $signed(SW'(15))) begin
        mant_c   = '0;
        guard_c  = 1'b0;
        sticky_c = 1'b1;
      end else begin
        mant_c   = MW'(frac1 >> sh_c);
        guard_c  = |(frac1 & (FRAC_W'(1) << (sh_c - 4'd1)));
        sticky_c = |(frac1 & ((FRAC_W'(1) << (sh_c - 4'd1)) - FRAC_W'(1)));
      end
    end
  end

  // Stage 2 register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2    <= 1'b0;
      sign2 <= 1'b0;
      cls2  <= CLS_ZERO;
      exp2  <= '0;
      mant2 <= '0;
      g2    <= 1'b0;
      st2   <= 1'b0;
    end else if (advance) begin
      v2    <= v1;
      sign2 <= sign1;
      cls2  <= cls1;
      exp2  <= biased1[6:0];
      mant2 <= mant_c;
      g2    <= guard_c;
      st2   <= sticky_c;
    end
  end

  // ---------------- stage 3: round and assemble ----------------
  logic        roundup_c;
  logic [19:0] rounded_c;
  logic [20:0] word_c;
  logic        ovf_c;
  logic        unf_c;
  logic        inx_c;

  // Round to nearest even; a carry out of the mantissa lands in exponent
  // field 1, which is exactly the smallest normal.
  always_comb begin
    roundup_c = g2 & (st2 | mant2[0]);
    rounded_c = {7'd0, mant2} + 20'(roundup_c);
    word_c    = {sign2, 20'd0};
    ovf_c     = 1'b0;
    unf_c     = 1'b0;
    inx_c     = 1'b0;
    case (cls2)
      CLS_NORM: word_c = {sign2, exp2, mant2};
      CLS_OVF: begin
        word_c = {sign2, 7'h7F, 13'd0};
        ovf_c  = 1'b1;
        inx_c  = 1'b1;
      end
      CLS_SUB: begin
        word_c = {sign2, rounded_c};
        inx_c  = g2 | st2;
        unf_c  = g2 | st2;
      end
      default: word_c = {sign2, 20'd0};
    endcase
  end

  // Output register: holds word and flags while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      word_out    <= '0;
      ovf_out     <= 1'b0;
      unf_out     <= 1'b0;
      inexact_out <= 1'b0;
    end else if (advance) begin
      out_valid   <= v2;
      word_out    <= word_c;
      ovf_out     <= ovf_c;
      unf_out     <= unf_c;
      inexact_out <= inx_c;
    end
  end

endmodule

// File: tb/tb_fp21_pack.sv
// Directed bench for fp21_pack: reset, single-vector latency and values,
// back-to-back throughput, stalled streaming, and reset with operands in flight.
module tb_fp21_pack;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        sign_in;
  logic [8:0]  exp_in;
  logic [13:0] frac_in;
  logic        out_valid;
  logic        out_ready;
  logic [20:0] word_out;
  logic        ovf_out;
  logic        unf_out;
  logic        inexact_out;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        s;
    int          e;
    logic [13:0] f;
    logic [20:0] w;
    logic        ovf;
    logic        unf;
    logic        inx;
  } vec_t;

  vec_t vecs [12];
  logic [23:0] exp_q [$];

  fp21_pack dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sign_in    (sign_in),
    .exp_in     (exp_in),
    .frac_in    (frac_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .word_out   (word_out),
    .ovf_out    (ovf_out),
    .unf_out    (unf_out),
    .inexact_out(inexact_out)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Hand-computed vectors: {sign, exp, frac} -> {word, ovf, unf, inexact}.
  task automatic init_vecs();
    vecs[0]  = '{1'b0,   0, 14'h2000, 21'h07E000, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1,  64, 14'h2000, 21'h1FE000, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, -63, 14'h2000, 21'h001000, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, -63, 14'h3FFF, 21'h002000, 1'b0, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, -76, 14'h3FFF, 21'h000001, 1'b0, 1'b1, 1'b1};
    vecs[5]  = '{1'b0, -80, 14'h2000, 21'h000000, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{1'b1,   5, 14'h0000, 21'h100000, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0,  63, 14'h3FFF, 21'h0FDFFF, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, -62, 14'h2ABC, 21'h002ABC, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, -64, 14'h2003, 21'h100801, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{1'b0, -64, 14'h2002, 21'h000800, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{1'b0, -77, 14'h3FFF, 21'h000000, 1'b0, 1'b1, 1'b1};
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_vec(input int i);
    in_valid = 1'b1;
    sign_in  = vecs[i].s;
    exp_in   = 9'(vecs[i].e);
    frac_in  = vecs[i].f;
  endtask

  task automatic drive_idle();
    in_valid = 1'b0;
    sign_in  = 1'b0;
    exp_in   = '0;
    frac_in  = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n     = 1'b0;
    out_ready = 1'b1;
    drive_idle();
    repeat (2) @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (word_out !== 21'd0) begin n_fail++; $display("FAIL reset_word got %h want 000000", word_out); end
    n_checks++; if ({ovf_out, unf_out, inexact_out} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {ovf_out, unf_out, inexact_out}); end
    rst_n = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    repeat (3) begin
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_spurious_valid got %b want 0", out_valid); end
    end
  endtask

  task automatic test_vectors();
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive_vec(i);
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL vec%0d_in_ready got %b want 1", i, in_ready); end
      @(negedge clk);
      drive_idle();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL vec%0d_early_valid1 got %b want 0", i, out_valid); end
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL vec%0d_early_valid2 got %b want 0", i, out_valid); end
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL vec%0d_latency got out_valid %b want 1", i, out_valid); end
      n_checks++; if (word_out !== vecs[i].w) begin n_fail++; $display("FAIL vec%0d_word got %h want %h", i, word_out, vecs[i].w); end
      n_checks++;
      if ({ovf_out, unf_out, inexact_out} !== {vecs[i].ovf, vecs[i].unf, vecs[i].inx}) begin
        n_fail++;
        $display("FAIL vec%0d_flags got ovf/unf/inx %b want %b", i,
                 {ovf_out, unf_out, inexact_out}, {vecs[i].ovf, vecs[i].unf, vecs[i].inx});
      end
    end
  endtask

  // Four table operands plus one non-normalized operand, one per cycle.
  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int j = 0; j < 9; j++) begin
      @(negedge clk);
      if (j >= 3 && j <= 7) begin
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid slot%0d got %b want 1", j, out_valid); end
        if (j - 3 < 4) begin
          n_checks++;
          if (word_out !== vecs[6 + j - 3].w) begin
            n_fail++; $display("FAIL b2b_word slot%0d got %h want %h", j, word_out, vecs[6 + j - 3].w);
          end
        end
      end else begin
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_bubble slot%0d got %b want 0", j, out_valid); end
      end
      if (j < 4) begin
        drive_vec(6 + j);
      end else if (j == 4) begin
        in_valid = 1'b1;
        sign_in  = 1'b0;
        exp_in   = '0;
        frac_in  = 14'h0005;
      end else begin
        drive_idle();
      end
    end
  endtask

  // Eight operands with out_ready toggling; scoreboard plus stall stability.
  task automatic test_stream();
    int          sent = 0;
    int          got  = 0;
    int          cyc  = 0;
    logic        stalled = 1'b0;
    logic [23:0] snap = '0;
    logic [23:0] exp_v;
    exp_q.delete();
    while (got < 8 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (stalled) begin
        n_checks++;
        if (out_valid !== 1'b1 || {ovf_out, unf_out, inexact_out, word_out} !== snap) begin
          n_fail++;
          $display("FAIL stream_stall_hold got v=%b %h want v=1 %h", out_valid,
                   {ovf_out, unf_out, inexact_out, word_out}, snap);
        end
      end
      out_ready = 1'($urandom_range(0, 1));
      if (sent < 8) drive_vec(sent);
      else drive_idle();
      #1;
      n_checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
        n_fail++; $display("FAIL stream_in_ready got %b want %b", in_ready, !out_valid || out_ready);
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL stream_extra_result got %h want none", word_out);
        end else begin
          exp_v = exp_q.pop_front();
          if ({ovf_out, unf_out, inexact_out, word_out} !== exp_v) begin
            n_fail++;
            $display("FAIL stream_result%0d got %h want %h", got, {ovf_out, unf_out, inexact_out, word_out}, exp_v);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({vecs[sent].ovf, vecs[sent].unf, vecs[sent].inx, vecs[sent].w});
        sent++;
      end
      stalled = out_valid && !out_ready;
      snap    = {ovf_out, unf_out, inexact_out, word_out};
    end
    n_checks++; if (got !== 8) begin n_fail++; $display("FAIL stream_count got %0d want 8", got); end
    n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL stream_leftover got %0d want 0", exp_q.size()); end
    @(negedge clk);
    drive_idle();
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_inflight();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_vec(i);
    end
    @(negedge clk);
    drive_idle();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL inflight_pre_valid got %b want 1", out_valid); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL inflight_rst_valid got %b want 0", out_valid); end
    n_checks++;
    if ({ovf_out, unf_out, inexact_out, word_out} !== 24'd0) begin
      n_fail++; $display("FAIL inflight_rst_outputs got %h want 000000", {ovf_out, unf_out, inexact_out, word_out});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL inflight_flushed cycle%0d got %b want 0", k, out_valid); end
    end
    @(negedge clk);
    drive_vec(3);
    @(negedge clk);
    drive_idle();
    repeat (2) @(negedge clk);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL inflight_after_valid got %b want 1", out_valid); end
    n_checks++; if (word_out !== vecs[3].w) begin n_fail++; $display("FAIL inflight_after_word got %h want %h", word_out, vecs[3].w); end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL inflight_single_result got %b want 0", out_valid); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    init_vecs();
    test_reset();
    test_vectors();
    test_back_to_back();
    test_stream();
    test_reset_inflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
